stickit_scan: RTL

Parametrised charlieplexed 7-segment scan driver for the StickIt! LED Digits module on a PMOD header. It succeeds the fixed 8-digit driver and adds:
- a configurable digit count and scan rate;
- 16-level PWM brightness;
- per-digit enable and leading-zero suppression;
- a dead-time slot against ghosting;
- frame-synchronous value snapshot (no tearing) with a FRAME strobe.

Outputs are split into level and enable vectors, and the top level builds the tri-state PMOD pads from them.

---
 rtl/stickit_scan.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/stickit_scan.sv
// stickit_scan
// Charlieplexed 7-segment scan driver for the StickIt! LED Digits module.
// Each digit owns one "common" line that is driven high while its slot is
// active. The remaining seven lines carry the segments and are pulled low
// for lit segments or released otherwise. The top level builds the PMOD
// tri-state pads from the S_OUT / S_OE pair.
//
// Parameters
//   NUM_DIGITS : number of active digits (1..8); always 8 lines
//   DIV_LOG2   : log2 of clock cycles per digit slot (>= 4)
//
// Ports
//   CLK      in   system clock
//   RESET    in   asynchronous active-high reset
//   VALUE    in   hex value, nibble k shown on digit k (nibble 0 = rightmost)
//   DIGIT_EN in   per-digit enable, digit k blanked when bit k = 0
//   LZ_BLANK in   leading-zero suppression enable
//   BRIGHT   in   brightness, 15 = full slot, 0 = 1/16 of the slot
//   S_OUT    out  line drive level
//   S_OE     out  line drive enable (0 = released / Z)
//   FRAME    out  one-cycle strobe following each value snapshot
module stickit_scan #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_LOG2   = 10
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [4*NUM_DIGITS-1:0] VALUE,
    input  logic [NUM_DIGITS-1:0]   DIGIT_EN,
    input  logic                    LZ_BLANK,
    input  logic [3:0]              BRIGHT,
    output logic [7:0]              S_OUT,
    output logic [7:0]              S_OE,
    output logic                    FRAME
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

    logic [DIV_LOG2-1:0]   cnt;
    logic [2:0]            idx;
    logic [4*NUM_DIGITS-1:0] sh;

    logic        cnt_max;
    logic        frame_end;
    logic [31:0] sh_pad;
    logic [7:0]  en_pad;
    logic [3:0]  digit;
    logic [7:0]  glyph;
    logic        upper_nonzero;
    logic        leading_zero;
    logic [3:0]  phase;
    logic        blank;
    logic [7:0]  common;
    logic [7:0]  low_mask;
    logic [7:0]  seg_lines;
    logic [7:0]  next_oe;
    logic [7:0]  next_out;

    assign cnt_max   = &cnt;
    assign frame_end = cnt_max && (idx == LAST_IDX);

    // Slot counter and digit index. The index only advances when the slot
    // counter wraps, and wraps itself after the last active digit.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (cnt_max) begin
                if (idx == LAST_IDX) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 3'd1;
                end
            end
        end
    end

    // Shadow copy of VALUE, refreshed only at the frame end so a frame never
    // mixes digits from two different values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sh <= '0;
        end else if (frame_end) begin
            sh <= VALUE;
        end
    end

    // Widen the shadow and enable vectors to the full 8-digit shape so the
    // index-driven selects below stay in range for any NUM_DIGITS.
    always_comb begin
        sh_pad = '0;
        en_pad = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            sh_pad[4*k +: 4] = sh[4*k +: 4];
            en_pad[k]        = DIGIT_EN[k];
        end
    end

    assign digit = sh_pad[{idx, 2'b00} +: 4];

    // Hex to lit-segment mask, bit0 = a ... bit6 = g. Bit 7 stays clear so
    // the line shift below never pushes a lit segment off the top.
    always_comb begin
        glyph = 8'h00;
        case (digit)
            4'h0: glyph = 8'h3F;
            4'h1: glyph = 8'h06;
            4'h2: glyph = 8'h5B;
            4'h3: glyph = 8'h4F;
            4'h4: glyph = 8'h66;
            4'h5: glyph = 8'h6D;
            4'h6: glyph = 8'h7D;
            4'h7: glyph = 8'h07;
            4'h8: glyph = 8'h7F;
            4'h9: glyph = 8'h67;
            4'hA: glyph = 8'h77;
            4'hB: glyph = 8'h7C;
            4'hC: glyph = 8'h39;
            4'hD: glyph = 8'h5E;
            4'hE: glyph = 8'h79;
            4'hF: glyph = 8'h71;
            default: glyph = 8'h00;
        endcase
    end

    // A digit is a leading zero when it and every more significant digit
    // are zero. Digit 0 is exempt so a zero value still shows one "0".
    always_comb begin
        upper_nonzero = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((3'(k) >= idx) && (sh[4*k +: 4] != 4'h0)) begin
                upper_nonzero = 1'b1;
            end
        end
        leading_zero = LZ_BLANK && (idx != 3'd0) && !upper_nonzero;
    end

    assign phase = cnt[DIV_LOG2-1 -: 4];

    assign blank = (cnt == '0) || (phase > BRIGHT) || !en_pad[idx] || leading_zero;

    // Segments below the common line map straight across; segments at or
    // above it move up one line to step around the common.
    always_comb begin
        common    = 8'd1 << idx;
        low_mask  = common - 8'd1;
        seg_lines = (glyph & low_mask) | ((glyph & ~low_mask) << 1);
        if (blank) begin
            next_oe  = 8'h00;
            next_out = 8'h00;
        end else begin
            next_oe  = seg_lines | common;
            next_out = common;
        end
    end

    // Registered line drive and frame strobe.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            S_OE  <= 8'h00;
            S_OUT <= 8'h00;
            FRAME <= 1'b0;
        end else begin
            S_OE  <= next_oe;
            S_OUT <= next_out;
            FRAME <= frame_end;
        end
    end

endmodule
